// File: rtl/vga_frame_grabber_if.sv
// Pixel-path bundle for vga_frame_grabber: VGA inputs, arm/control, and the tagged pixel stream.
// master = the grabber, slave = the VGA source plus stream sink and controller.
interface vga_frame_grabber_if #(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned NFRM_W  = 8
);
    logic                   vga_vs;
    logic                   vga_blank_n;
    logic [COLOR_W-1:0]     vga_r;
    logic [COLOR_W-1:0]     vga_g;
    logic [COLOR_W-1:0]     vga_b;
    logic                   start;
    logic [NFRM_W-1:0]      num_frames;
    logic [3*COLOR_W-1:0]   pix_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   pix_eol;
    logic                   pix_eof;
    logic [NFRM_W-1:0]      frame_idx;
    logic                   busy;
    logic                   done;
    logic                   overflow;
    logic                   frame_err;

    modport master (
        input  vga_vs, vga_blank_n, vga_r, vga_g, vga_b, start, num_frames, pix_ready,
        output pix_data, pix_valid, pix_eol, pix_eof, frame_idx, busy, done, overflow, frame_err
    );

    modport slave (
        output vga_vs, vga_blank_n, vga_r, vga_g, vga_b, start, num_frames, pix_ready,
        input  pix_data, pix_valid, pix_eol, pix_eof, frame_idx, busy, done, overflow, frame_err
    );
endinterface

// File: rtl/vga_frame_grabber.sv
// Captures NUM_FRAMES VGA frames into a FWFT FIFO feeding a valid/ready stream with EOL/EOF tags.
// Optional BMP header words per frame when VGA_GRABBER_BMP_HEADER_EN is defined.
module vga_frame_grabber #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NFRM_W     = 8
) (
    input logic                clock_25,
    input logic                reset_n,
    vga_frame_grabber_if.master bus
);
    localparam int unsigned PIX_W  = 3 * COLOR_W;
    localparam int unsigned WORD_W = PIX_W + 2;
    localparam int unsigned COL_W  = $clog2(H_ACTIVE + 1);
    localparam int unsigned ROW_W  = $clog2(V_ACTIVE + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef VGA_GRABBER_BMP_HEADER_EN
    typedef enum logic [2:0] {StIdle, StHdr, StWaitVs, StCapture, StDrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWaitVs, StCapture, StDrain} state_e;
`endif

    state_e              state_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [NFRM_W-1:0]   frames_left_q;
    logic [NFRM_W-1:0]   frame_idx_q;
    logic                trunc_q, busy_q, done_q, overflow_q, frame_err_q;

    // Input sampling: one register stage, plus the previous value for edge detection.
    logic                vs_q, vs_prev_q, blank_q, blank_prev_q;
    logic [PIX_W-1:0]    pix_q;
    logic                vs_fall, blank_fall;

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            vs_q         <= 1'b0;
            vs_prev_q    <= 1'b0;
            blank_q      <= 1'b0;
            blank_prev_q <= 1'b0;
            pix_q        <= '0;
        end else begin
            vs_q         <= bus.vga_vs;
            vs_prev_q    <= vs_q;
            blank_q      <= bus.vga_blank_n;
            blank_prev_q <= blank_q;
            pix_q        <= {bus.vga_b, bus.vga_g, bus.vga_r};
        end
    end

    assign vs_fall    = vs_prev_q & ~vs_q;
    assign blank_fall = blank_prev_q & ~blank_q;

    // FIFO: word = {pixel, eol, eof}
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                push_req, push_ok, pop, full, pix_push, eol, drain_go;
    logic [WORD_W-1:0]   push_word, head;

    assign full     = (count_q == CNT_FULL);
    assign pop      = (count_q != '0) & bus.pix_ready;
    assign push_ok  = push_req & (~full | pop);
    assign pix_push = (state_q == StCapture) & blank_q & (col_q < COL_MAX);
    assign eol      = (col_q == COL_LAST);

`ifdef VGA_GRABBER_BMP_HEADER_EN
    localparam int unsigned HDR_WORDS = 18;
    localparam logic [31:0] IMG_SIZE  = 32'(3 * H_ACTIVE * V_ACTIVE);

    if (COLOR_W != 8) begin : g_bad_color_w
        $error("BMP header output requires COLOR_W == 8");
    end

    logic [4:0] hdr_cnt_q;
    logic       hdr_phase, hdr_last;

    // Each header field is little-endian: pick the field, then the byte offset inside it.
    function automatic logic [7:0] hdr_byte(input int unsigned i);
        logic [31:0] v;
        int unsigned o;
        v = '0;
        o = 0;
        if (i < 2)       begin v = 32'h0000_4D42;       o = i;      end
        else if (i < 6)  begin v = IMG_SIZE + 32'd54;   o = i - 2;  end
        else if (i < 10) begin v = '0;                  o = 0;      end
        else if (i < 14) begin v = 32'd54;              o = i - 10; end
        else if (i < 18) begin v = 32'd40;              o = i - 14; end
        else if (i < 22) begin v = 32'(H_ACTIVE);       o = i - 18; end
        else if (i < 26) begin v = 32'(V_ACTIVE);       o = i - 22; end
        else if (i < 28) begin v = 32'd1;               o = i - 26; end
        else if (i < 30) begin v = 32'd24;              o = i - 28; end
        else if (i < 34) begin v = '0;                  o = 0;      end
        else if (i < 38) begin v = IMG_SIZE;            o = i - 34; end
        else if (i < 42) begin v = 32'h1625;            o = i - 38; end
        else if (i < 46) begin v = 32'h1625;            o = i - 42; end
        return 8'(v >> (8 * o));
    endfunction

    function automatic logic [23:0] hdr_word(input int unsigned k);
        return {hdr_byte(3 * k + 2), hdr_byte(3 * k + 1), hdr_byte(3 * k)};
    endfunction

    assign hdr_phase = (state_q == StHdr) |
                       ((state_q == StDrain) & (frames_left_q > NFRM_W'(1)));
    assign hdr_last  = hdr_phase & push_ok & (hdr_cnt_q == 5'(HDR_WORDS - 1));
    assign drain_go  = hdr_last;
`else
    assign drain_go  = 1'b1;
`endif

    always_comb begin
        push_req  = pix_push;
        push_word = {pix_q, eol, eol & (row_q == ROW_LAST)};
`ifdef VGA_GRABBER_BMP_HEADER_EN
        // Header words stall on a full FIFO instead of being dropped.
        if (hdr_phase) begin
            push_req  = 1'b1;
            push_word = {PIX_W'(hdr_word(32'(hdr_cnt_q))), 2'b00};
        end
`endif
    end

    always_ff @(posedge clock_25) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok & ~pop)      count_q <= count_q + CNT_W'(1);
            else if (~push_ok & pop) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            row_q         <= '0;
            col_q         <= '0;
            frames_left_q <= '0;
            frame_idx_q   <= '0;
            trunc_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef VGA_GRABBER_BMP_HEADER_EN
            hdr_cnt_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (pix_push & ~push_ok) overflow_q <= 1'b1;
`ifdef VGA_GRABBER_BMP_HEADER_EN
            if (hdr_phase & push_ok) hdr_cnt_q <= hdr_last ? '0 : hdr_cnt_q + 5'd1;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        frames_left_q <= (bus.num_frames == '0) ? NFRM_W'(1) : bus.num_frames;
                        busy_q        <= 1'b1;
                        overflow_q    <= 1'b0;
                        frame_err_q   <= 1'b0;
                        frame_idx_q   <= '0;
`ifdef VGA_GRABBER_BMP_HEADER_EN
                        state_q       <= StHdr;
`else
                        state_q       <= StWaitVs;
`endif
                    end
                end
`ifdef VGA_GRABBER_BMP_HEADER_EN
                StHdr: begin
                    if (hdr_last) state_q <= StWaitVs;
                end
`endif
                StWaitVs: begin
                    if (vs_fall) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    if (vs_fall) begin
                        frame_err_q <= 1'b1;
                        trunc_q     <= 1'b1;
                        state_q     <= StDrain;
                    end else if (blank_fall && col_q != '0) begin
                        col_q <= '0;
                        row_q <= row_q + ROW_W'(1);
                        if (row_q == ROW_LAST) begin
                            trunc_q <= 1'b0;
                            state_q <= StDrain;
                        end
                    end else if (blank_q && col_q != COL_MAX) begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
                StDrain: begin
                    if (frames_left_q > NFRM_W'(1)) begin
                        if (drain_go) begin
                            frames_left_q <= frames_left_q - NFRM_W'(1);
                            frame_idx_q   <= frame_idx_q + NFRM_W'(1);
                            row_q         <= '0;
                            col_q         <= '0;
                            // A truncating VS edge already opened the next frame.
                            state_q       <= trunc_q ? StCapture : StWaitVs;
                        end
                    end else if (count_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign head          = mem[rd_ptr_q];
    assign bus.pix_valid = (count_q != '0);
    assign bus.pix_data  = bus.pix_valid ? head[WORD_W-1:2] : '0;
    assign bus.pix_eol   = bus.pix_valid & head[1];
    assign bus.pix_eof   = bus.pix_valid & head[0];
    assign bus.frame_idx = frame_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_vga_frame_grabber.sv
// Scoreboard bench for vga_frame_grabber on a 4x3 raster with a 4-entry FIFO.
module tb_vga_frame_grabber;
    localparam int unsigned H = 4, V = 3, CW = 8, NW = 8, DEPTH = 4;
    localparam int HBLANK = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_grabber_if #(.COLOR_W(CW), .NFRM_W(NW)) bus ();

    vga_frame_grabber #(
        .H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(CW), .FIFO_DEPTH(DEPTH), .NFRM_W(NW)
    ) dut (
        .clock_25(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [23:0] data;
        logic        eol;
        logic        eof;
    } word_t;

    word_t exp_q[$];
    int n_checks = 0, n_pass = 0;
    int done_cnt = 0, done_base = 0;
    int rdy_mode = 0;    // 0: always ready, 1: random during active video, 2: never ready
    int cap_left = 0, cap_idx = 0;
    bit rand_pix = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 64'({bus.pix_valid, bus.pix_data, bus.pix_eol, bus.pix_eof, bus.frame_idx,
                       bus.busy, bus.done, bus.overflow, bus.frame_err}), 64'd0);
    endtask

    // Monitor: decides READY for the coming edge, then scores any word that will transfer on it.
    initial begin
        word_t w;
        bus.pix_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = bus.vga_blank_n ? 1'($urandom) : 1'b1;
                default: bus.pix_ready = 1'b0;
            endcase
            if (bus.done) done_cnt++;
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("word_pending", 64'(exp_q.size() > 0), 64'd1);
                end else begin
                    w = exp_q.pop_front();
                    chk("word", 64'({bus.pix_data, bus.pix_eol, bus.pix_eof}),
                        64'({w.data, w.eol, w.eof}));
                end
            end
        end
    end

    task automatic arm(input int nf);
        @(negedge clk);
        bus.num_frames = NW'(nf);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cap_left  = (nf == 0) ? 1 : nf;
        cap_idx   = 0;
        done_base = done_cnt;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("overflow_cleared", 64'(bus.overflow), 64'd0);
        chk("frame_err_cleared", 64'(bus.frame_err), 64'd0);
    endtask

    // Drives one frame; rows below `lines` are omitted; reset pulses at (rst_row, col 2).
    task automatic drive_frame(input int lines, input int rst_row);
        bit cap;
        int kept;
        logic [7:0] r, g, b;
        word_t w;
        cap = (cap_left > 0);
        if (cap) cap_left--;
        kept = 0;
        repeat (2) begin @(negedge clk); bus.vga_vs = 1'b0; bus.vga_blank_n = 1'b0; end
        repeat (3) begin @(negedge clk); bus.vga_vs = 1'b1; end
        for (int row = 0; row < lines; row++) begin
            if (cap && row == 1) chk("frame_idx", 64'(bus.frame_idx), 64'(cap_idx));
            for (int col = 0; col < int'(H); col++) begin
                if (row == rst_row && col == 2) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs("reset_mid_capture");
                    exp_q.delete();
                    cap = 1'b0;
                end
                @(negedge clk);
                r = rand_pix ? 8'($urandom) : 8'(row * 16 + col);
                g = 8'($urandom);
                b = 8'($urandom);
                bus.vga_r = r;
                bus.vga_g = g;
                bus.vga_b = b;
                bus.vga_blank_n = 1'b1;
                if (cap && (rdy_mode != 2 || kept < int'(DEPTH))) begin
                    w.data = {b, g, r};
                    w.eol  = (col == int'(H) - 1);
                    w.eof  = w.eol && (row == int'(V) - 1);
                    exp_q.push_back(w);
                    kept++;
                end
            end
            repeat (HBLANK) begin
                @(negedge clk);
                bus.vga_blank_n = 1'b0;
                rst_n = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        if (cap) cap_idx++;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_cnt - done_base), 64'd1);
        repeat (3) @(negedge clk);
        chk("single_done", 64'(done_cnt - done_base), 64'd1);
        chk("busy_low_after_done", 64'(bus.busy), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int nf;
        bus.vga_vs = 1'b1;
        bus.vga_blank_n = 1'b0;
        bus.vga_r = '0;
        bus.vga_g = '0;
        bus.vga_b = '0;
        bus.start = 1'b0;
        bus.num_frames = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle_outputs");

        // Single frame, always ready.
        arm(1);
        drive_frame(3, -1);
        wait_done(200);
        chk("overflow_single", 64'(bus.overflow), 64'd0);
        chk("frame_err_single", 64'(bus.frame_err), 64'd0);

        // Three frames; a START while busy with a different count is ignored.
        arm(3);
        drive_frame(3, -1);
        bus.num_frames = NW'(5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drive_frame(3, -1);
        drive_frame(3, -1);
        wait_done(200);
        chk("frame_idx_last", 64'(bus.frame_idx), 64'd2);

        // Sink stalled for the whole frame: only the first DEPTH pixels survive.
        rdy_mode = 2;
        arm(1);
        drive_frame(3, -1);
        chk("overflow_set", 64'(bus.overflow), 64'd1);
        chk("frame_err_on_overflow", 64'(bus.frame_err), 64'd0);
        chk("busy_while_stalled", 64'(bus.busy), 64'd1);
        chk("words_held", 64'(exp_q.size()), 64'(DEPTH));
        rdy_mode = 0;
        wait_done(200);
        chk("overflow_sticky", 64'(bus.overflow), 64'd1);

        // Early VS after two rows truncates frame 0; that VS starts frame 1.
        arm(2);
        drive_frame(2, -1);
        drive_frame(3, -1);
        chk("frame_err_set", 64'(bus.frame_err), 64'd1);
        wait_done(200);
        chk("frame_err_sticky", 64'(bus.frame_err), 64'd1);

        // Reset in row 1 abandons the capture; a fresh START captures cleanly.
        arm(1);
        drive_frame(3, 1);
        chk("no_done_after_reset", 64'(done_cnt - done_base), 64'd0);
        chk("busy_after_reset", 64'(bus.busy), 64'd0);
        arm(1);
        drive_frame(3, -1);
        wait_done(200);

        // Random pixels, random in-line backpressure, random frame counts (0 means 1).
        rand_pix = 1'b1;
        rdy_mode = 1;
        for (int t = 0; t < 4; t++) begin
            nf = int'($urandom_range(0, 3));
            arm(nf);
            for (int f = 0; f < ((nf == 0) ? 1 : nf); f++) drive_frame(3, -1);
            wait_done(300);
            chk("overflow_random", 64'(bus.overflow), 64'd0);
            repeat (int'($urandom_range(1, 8))) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
